// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder slice plus a carry flop, LSB first.
// Result, carry-out and signed overflow are registered at the final bit edge.
module serial_adder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  a_sr_q, a_sr_d;
    logic [W-1:0]  b_sr_q, b_sr_d;
    logic [W-1:0]  s_sr_q, s_sr_d;
    logic          carry_q, carry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sum_q, sum_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    logic          bit_s;
    logic          bit_c;
    logic [W-1:0]  s_shift;

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        bit_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        bit_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

        // Written as shift-then-insert so the W=1 case needs no special slice.
        s_shift        = s_sr_q >> 1;
        s_shift[W-1]   = bit_s;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                s_sr_d  = s_shift;
                carry_d = bit_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // carry_q here is the carry into the MSB slice.
                    sum_d   = s_shift;
                    cout_d  = bit_c;
                    ovf_d   = carry_q ^ bit_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, random ops against an
// arithmetic model, multi-cycle corner sequences, and a W=1 instance.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done;
    logic [7:0] sum;
    logic       cout, ovf;

    logic       s1_start;
    logic [0:0] s1_a, s1_b;
    logic       s1_cin;
    logic       s1_busy, s1_done;
    logic [0:0] s1_sum;
    logic       s1_cout, s1_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder #(.W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );

    serial_adder #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .start(s1_start), .a(s1_a), .b(s1_b), .cin(s1_cin),
        .busy(s1_busy), .done(s1_done), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Unsigned sum modulo 2^w, carry-out, and signed overflow as range violation.
    function automatic void model(input int w, input int av, input int bv, input int ci,
                                  output int s, output int co, output int ov);
        int t, sa, sb, st;
        t  = av + bv + ci;
        s  = t % (1 << w);
        co = (t >> w) & 1;
        sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        st = sa + sb + ci;
        ov = (st < -(1 << (w - 1)) || st > (1 << (w - 1)) - 1) ? 1 : 0;
    endfunction

    // One operation on the W=8 DUT; inputs scrambled after acceptance.
    task automatic run_op(input logic [7:0] a_i, input logic [7:0] b_i, input logic cin_i,
                          output int s, output int co, output int ov,
                          output int lat, output int bcnt, output int held);
        int prev;
        @(negedge clk);
        start = 1'b1; a = a_i; b = b_i; cin = cin_i;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        prev = sum; lat = -1; bcnt = 0; held = 1; s = 0; co = 0; ov = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = i; s = sum; co = cout; ov = ovf;
                break;
            end
            if (sum != prev) held = 0;
            a = 8'($urandom); b = 8'($urandom);
        end
        @(negedge clk);
        if (busy || done) bcnt = -1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int s, co, ov, lat, bcnt, held;
        int es, eco, eov;
        int dones, got, pulses, last, stable;
        logic [7:0] ra, rb;
        logic       rc;

        vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        s1_start = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_sum",  sum,  0);
        check("reset_cout", cout, 0);
        check("reset_ovf",  ovf,  0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, ov, lat, bcnt, held);
            check($sformatf("vec%0d_sum", i),  s,  vecs[i].sum);
            check($sformatf("vec%0d_cout", i), co, vecs[i].cout);
            check($sformatf("vec%0d_ovf", i),  ov, vecs[i].ovf);
            check($sformatf("vec%0d_latency", i), lat, 8);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, 9);
            check($sformatf("vec%0d_sum_held", i), held, 1);
        end

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            model(8, int'(ra), int'(rb), int'(rc), es, eco, eov);
            run_op(ra, rb, rc, s, co, ov, lat, bcnt, held);
            check($sformatf("rnd%0d_sum", i),  s,  es);
            check($sformatf("rnd%0d_cout", i), co, eco);
            check($sformatf("rnd%0d_ovf", i),  ov, eov);
            check($sformatf("rnd%0d_latency", i), lat, 8);
        end

        // Second start during RUN must be dropped.
        @(negedge clk);
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0; got = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin dones++; got = sum; end
            a = (i == 2) ? 8'hAA : 8'($urandom);
            b = 8'($urandom); cin = 1'($urandom);
            start = (i == 2);
        end
        start = 1'b0;
        check("ignore_done_count", dones, 1);
        check("ignore_sum", got, 8'h30);

        // Async reset between E4 and E5 aborts the operation.
        @(negedge clk);
        start = 1'b1; a = 8'h05; b = 8'h06; cin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum",  sum,  0);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);
        run_op(8'h01, 8'h02, 1'b0, s, co, ov, lat, bcnt, held);
        check("after_abort_sum", s, 8'h03);
        check("after_abort_latency", lat, 8);

        // start held high: one result every W+2 cycles.
        @(negedge clk);
        start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
        pulses = 0; last = -1; stable = 1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) begin
                if (pulses > 0) check("b2b_spacing", i - last, 10);
                check("b2b_sum", sum, 8'h33);
                pulses++;
                last = i;
            end else if (pulses > 0 && sum != 8'h33) begin
                stable = 0;
            end
        end
        start = 1'b0;
        check("b2b_pulses", pulses, 4);
        check("b2b_stable", stable, 1);
        repeat (12) @(negedge clk);

        // W=1: one bit edge, done in the cycle after E1.
        for (int i = 0; i < 8; i++) begin
            model(1, i & 1, (i >> 1) & 1, (i >> 2) & 1, es, eco, eov);
            @(negedge clk);
            s1_start = 1'b1; s1_a = 1'(i); s1_b = 1'(i >> 1); s1_cin = 1'(i >> 2);
            @(posedge clk);
            #1 s1_start = 1'b0;
            @(negedge clk);
            check($sformatf("w1_%0d_early_done", i), s1_done, 0);
            @(negedge clk);
            check($sformatf("w1_%0d_done", i), s1_done, 1);
            check($sformatf("w1_%0d_sum", i),  s1_sum,  es);
            check($sformatf("w1_%0d_cout", i), s1_cout, eco);
            check($sformatf("w1_%0d_ovf", i),  s1_ovf,  eov);
            @(negedge clk);
            check($sformatf("w1_%0d_idle", i), s1_busy, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial W-bit full adder: the addition counterpart of the team's subtractor cells.
- Latches two operands and a carry-in on a start pulse, then adds one bit per clock, LSB first, through a single full-adder slice and a carry flip-flop.
- Reports sum, carry-out and signed overflow with a one-cycle done pulse.
- Used where area matters more than latency, e.g. accumulate paths fed by slow control logic.

Parameters:
W, 8, operand and sum width in bits (W >= 1)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
a  input  W  operand A, sampled on the accepting edge
b  input  W  operand B, sampled on the accepting edge
cin  input  1  carry-in, sampled on the accepting edge
busy  output  1  high while state is RUN or DONE
done  output  1  one-cycle pulse: result valid
sum  output  W  result (a + b + cin) mod 2^W
cout  output  1  carry out of bit W-1
ovf  output  1  signed overflow: carry into bit W-1 XOR cout

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; shift registers, carry FF and bit counter = 0.
  - Outputs: sum=0, cout=0, ovf=0, busy=0, done=0.
  - Reset asserted mid-operation aborts it; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge E0 loads A_sr<=a, B_sr<=b, carry<=cin, cnt<=0, state<=RUN. start=0 stays in IDLE.
  - RUN: each edge computes s = A_sr[0]^B_sr[0]^carry and c = maj(A_sr[0], B_sr[0], carry).
    - A_sr and B_sr shift right.
    - s shifts into S_sr at the MSB end; carry<=c; cnt<=cnt+1.
    - On the edge where cnt==W-1 (the W-th bit edge): state<=DONE.
    - The carry-in to the final bit is captured for ovf.
  - DONE: lasts exactly one cycle; done=1, busy=1. The next edge returns to IDLE.
- Latency:
  - start accepted at edge E0; bits processed at edges E1..EW.
  - done high during the cycle following EW; sum, cout and ovf are valid from EW.
  - A new start can be accepted no earlier than edge EW+2, which is the first IDLE cycle. Throughput is one operation per W+2 cycles.
- Output hold:
  - sum, cout and ovf update only at EW (the transition to DONE). They hold until the next completion or reset.
  - They do not reflect partial results during RUN.
- start while busy (RUN or DONE) is ignored with no queuing.
- a, b and cin may change freely after E0 without affecting the result.
- W=1: a single RUN edge, then DONE. ovf = carry-in XOR cout of bit 0.
- Counter width: clog2(W+1) bits. It never wraps within an operation.
- Wrap-around: the sum is modulo 2^W; cout carries the lost bit.

Test Plan:
- W=8, a=0x3C, b=0x05, cin=0, start at E0 -> done pulse in the cycle after E8; sum=0x41, cout=0, ovf=0; busy high for exactly 9 cycles.
- W=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Also a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1. Also a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
- W=8, a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0. Also a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, ovf=0.
- Start a=0x10, b=0x20; pulse start again at E3 with a=0xAA, and change a/b every cycle -> exactly one done; sum=0x30; the second start is ignored.
- Start an operation, assert rst asynchronously between E4 and E5 -> all outputs 0 immediately, no done. After release, start a=0x01, b=0x02 -> sum=0x03 after 8 bit edges.
- Back-to-back: hold start=1 continuously with a=0x11, b=0x22 -> results 0x33 with done pulses spaced exactly W+2=10 cycles apart; sum is stable between pulses.
